alu_hs: RTL and testbench

- Parametrised successor to the team's 8-bit combinational ALU; same result/flag conventions, generalised to WIDTH bits.
- Adds a registered output, valid/ready handshakes on both sides, and a persistent carry flag for ADC/SBB multi-word chaining.
- Adds signed overflow, an illegal-opcode flag, and an iterative shift-add unsigned multiply.
- Sits between an instruction sequencer and a writeback/consumer stage.

---
 rtl/alu_hs.sv | 208 ++++++++++++++++++++
 tb/tb_alu_hs.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_hs.sv
`default_nettype none
// ============================================================================
// Module   : alu_hs
// Purpose  : WIDTH-bit ALU with registered result/flags, valid/ready
//            handshakes on input and output, a persistent carry flag for
//            ADC/SBB chaining, and an iterative shift-add unsigned multiply.
// Ports    : clk, rst_n           - clock, async active-low reset
//            in_valid/in_ready    - operand/opcode handshake
//            a, b, opcode         - operands and operation select
//            out_valid/out_ready  - result handshake
//            result, carry, negative, zero, overflow, illegal - outputs
// Revision : 1.0 - initial release
// ============================================================================
module alu_hs #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_ADC = 4'b1000;
  localparam logic [3:0] OP_SBB = 4'b1001;
  localparam logic [3:0] OP_SAR = 4'b1010;
  localparam logic [3:0] OP_ROL = 4'b1011;
  localparam logic [3:0] OP_ROR = 4'b1100;
  localparam logic [3:0] OP_CMP = 4'b1101;
  localparam logic [3:0] OP_MUL = 4'b1110;
  localparam logic [3:0] OP_ILL = 4'b1111;

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t state, state_d;

  // Persistent carry from the last completed operation.
  logic cflag;

  // Multiplier datapath: multiplicand shifts left, multiplier shifts right.
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] mul_sum;

  logic accept, load_alu, mul_done;

  // Shared adder for ADD/SUB/ADC/SBB/CMP.
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic             add_ovf;

  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_ovf, alu_ill, alu_neg, alu_zero, is_cmp;

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign load_alu = accept && (opcode != OP_MUL);
  assign mul_done = (state == ST_MUL) && (count == LAST);
  assign mul_sum  = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    add_y   = b;
    add_cin = 1'b0;
    case (opcode)
      OP_SUB, OP_CMP: begin add_y = ~b; add_cin = 1'b1;  end
      OP_ADC:         begin             add_cin = cflag; end
      OP_SBB:         begin add_y = ~b; add_cin = cflag; end
      default: ;
    endcase
  end

  assign sum     = {1'b0, a} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
  // Overflow: addends agree in sign but the sum does not.
  assign add_ovf = (a[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    is_cmp    = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_ADC, OP_SBB: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = add_ovf;
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_SHL: begin alu_res = {a[WIDTH-2:0], 1'b0};       alu_carry = a[WIDTH-1]; end
      OP_SHR: begin alu_res = {1'b0, a[WIDTH-1:1]};       alu_carry = a[0];       end
      OP_SAR: begin alu_res = {a[WIDTH-1], a[WIDTH-1:1]}; alu_carry = a[0];       end
      OP_ROL: begin alu_res = {a[WIDTH-2:0], a[WIDTH-1]}; alu_carry = a[WIDTH-1]; end
      OP_ROR: begin alu_res = {a[0], a[WIDTH-1:1]};       alu_carry = a[0];       end
      OP_CMP: begin
        alu_res   = a;
        alu_carry = sum[WIDTH];
        alu_ovf   = add_ovf;
        is_cmp    = 1'b1;
      end
      OP_ILL: alu_ill = 1'b1;
      default: ;
    endcase
  end

  // CMP reports sign/zero of the difference rather than of the passed-through a.
  assign alu_neg  = is_cmp ? sum[WIDTH-1] : alu_res[WIDTH-1];
  assign alu_zero = is_cmp ? (sum[WIDTH-1:0] == '0) : (alu_res == '0);

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (accept && (opcode == OP_MUL)) state_d = ST_MUL;
      ST_MUL:  if (count == LAST)                state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (state == ST_IDLE) begin
      if (accept && (opcode == OP_MUL)) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        count  <= '0;
      end
    end else begin
      acc    <= mul_sum;
      mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      count  <= count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      cflag     <= 1'b0;
    end else if (load_alu) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      carry     <= alu_carry;
      negative  <= alu_neg;
      zero      <= alu_zero;
      overflow  <= alu_ovf;
      illegal   <= alu_ill;
      cflag     <= alu_carry;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= mul_sum[WIDTH-1:0];
      carry     <= |mul_sum[2*WIDTH-1:WIDTH];
      negative  <= mul_sum[WIDTH-1];
      zero      <= (mul_sum[WIDTH-1:0] == '0);
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      cflag     <= |mul_sum[2*WIDTH-1:WIDTH];
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_hs
// Purpose  : Directed self-checking bench for alu_hs at WIDTH=8 and WIDTH=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_hs;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       iv8, ir8, ov8, or8;
  logic [7:0] a8, b8, r8;
  logic [3:0] op8;
  logic       c8, n8, z8, v8, il8;

  // WIDTH=16 instance
  logic        iv16, ir16, ov16, or16;
  logic [15:0] a16, b16, r16;
  logic [3:0]  op16;
  logic        c16, n16, z16, v16, il16;

  int n_checks = 0;
  int n_fail   = 0;

  alu_hs #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .opcode(op8), .out_valid(ov8), .out_ready(or8),
    .result(r8), .carry(c8), .negative(n8), .zero(z8),
    .overflow(v8), .illegal(il8)
  );

  alu_hs #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .opcode(op16), .out_valid(ov16), .out_ready(or16),
    .result(r16), .carry(c16), .negative(n16), .zero(z16),
    .overflow(v16), .illegal(il16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flags8(input string tag, input logic [7:0] r, input logic c,
                        input logic n, input logic z, input logic v, input logic il);
    chk({tag, ".valid"}, ov8, 1'b1);
    chk({tag, ".result"}, r8, r);
    chk({tag, ".carry"}, c8, c);
    chk({tag, ".negative"}, n8, n);
    chk({tag, ".zero"}, z8, z);
    chk({tag, ".overflow"}, v8, v);
    chk({tag, ".illegal"}, il8, il);
  endtask

  task automatic flags16(input string tag, input logic [15:0] r, input logic c,
                         input logic n, input logic z, input logic v, input logic il);
    chk({tag, ".valid"}, ov16, 1'b1);
    chk({tag, ".result"}, r16, r);
    chk({tag, ".carry"}, c16, c);
    chk({tag, ".negative"}, n16, n);
    chk({tag, ".zero"}, z16, z);
    chk({tag, ".overflow"}, v16, v);
    chk({tag, ".illegal"}, il16, il);
  endtask

  initial begin
    iv8 = 0; a8 = 0; b8 = 0; op8 = 0; or8 = 1;
    iv16 = 0; a16 = 0; b16 = 0; op16 = 0; or16 = 1;

    // Reset state
    tick(); tick();
    chk("rst.out_valid", ov8, 1'b0);
    chk("rst.result", r8, 8'h00);
    chk("rst.illegal", il8, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("rst.in_ready", ir8, 1'b1);
    chk("rst16.out_valid", ov16, 1'b0);

    // ADD 0x7F + 0x01: signed overflow
    iv8 = 1; op8 = 4'b0000; a8 = 8'h7F; b8 = 8'h01;
    tick();
    iv8 = 0;
    flags8("add7f", 8'h80, 0, 1, 0, 1, 0);
    tick();
    chk("add7f.consumed", ov8, 1'b0);

    // 16-bit add 0x01FF + 0x0001 via ADD then ADC, then SBB
    iv8 = 1; op8 = 4'b0000; a8 = 8'hFF; b8 = 8'h01;
    tick();
    flags8("addff", 8'h00, 1, 0, 1, 0, 0);
    op8 = 4'b1000; a8 = 8'h01; b8 = 8'h00;
    tick();
    flags8("adc", 8'h02, 0, 0, 0, 0, 0);
    op8 = 4'b1001; a8 = 8'h00; b8 = 8'h00;
    tick();
    iv8 = 0;
    flags8("sbb", 8'hFF, 0, 1, 0, 0, 0);
    tick();
    chk("sbb.consumed", ov8, 1'b0);

    // Backpressure hold, then accept+consume on the same edge
    or8 = 0;
    iv8 = 1; op8 = 4'b0000; a8 = 8'd3; b8 = 8'd4;
    tick();
    iv8 = 0;
    flags8("bp", 8'd7, 0, 0, 0, 0, 0);
    chk("bp.in_ready", ir8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.hold.valid", ov8, 1'b1);
      chk("bp.hold.result", r8, 8'd7);
    end
    or8 = 1;
    iv8 = 1; op8 = 4'b0100; a8 = 8'hF0; b8 = 8'hFF;
    #1;
    chk("bp.in_ready_up", ir8, 1'b1);
    tick();
    iv8 = 0;
    flags8("xor", 8'h0F, 0, 0, 0, 0, 0);
    tick();
    chk("xor.consumed", ov8, 1'b0);

    // SHL / ROR quick checks
    iv8 = 1; op8 = 4'b0110; a8 = 8'hC1;
    tick();
    flags8("shl", 8'h82, 1, 1, 0, 0, 0);
    op8 = 4'b1100; a8 = 8'h01;
    tick();
    iv8 = 0;
    flags8("ror", 8'h80, 1, 1, 0, 0, 0);
    tick();

    // MUL 20*13 = 260 -> 0x04, carry 1; inputs wiggled during the multiply
    iv8 = 1; op8 = 4'b1110; a8 = 8'd20; b8 = 8'd13;
    tick();
    iv8 = 0; a8 = 8'hAA; b8 = 8'h55; op8 = 4'b0000;
    chk("mul1.busy0", ir8, 1'b0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("mul1.busy", ir8, 1'b0);
      chk("mul1.novalid", ov8, 1'b0);
    end
    tick();
    flags8("mul1", 8'h04, 1, 0, 0, 0, 0);
    chk("mul1.in_ready", ir8, 1'b1);

    // cflag from MUL feeds ADC: 0 + 0 + 1
    iv8 = 1; op8 = 4'b1000; a8 = 8'h00; b8 = 8'h00;
    tick();
    iv8 = 0;
    flags8("adc_mul", 8'h01, 0, 0, 0, 0, 0);
    tick();

    // MUL 15*15 = 225
    iv8 = 1; op8 = 4'b1110; a8 = 8'd15; b8 = 8'd15;
    tick();
    iv8 = 0;
    for (int i = 1; i < 8; i++) tick();
    chk("mul2.early", ov8, 1'b0);
    tick();
    flags8("mul2", 8'hE1, 0, 1, 0, 0, 0);
    tick();

    // Set cflag=1, then abort a MUL with reset at iteration 3
    iv8 = 1; op8 = 4'b0000; a8 = 8'hFF; b8 = 8'h01;
    tick();
    iv8 = 0;
    chk("pre.carry", c8, 1'b1);
    tick();
    iv8 = 1; op8 = 4'b1110; a8 = 8'd20; b8 = 8'd13;
    tick();
    iv8 = 0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("abort.out_valid", ov8, 1'b0);
    chk("abort.result", r8, 8'h00);
    chk("abort.carry", c8, 1'b0);
    chk("abort.zero", z8, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort.in_ready", ir8, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort.no_valid", ov8, 1'b0);
    end
    // cflag cleared by reset
    iv8 = 1; op8 = 4'b1000; a8 = 8'h00; b8 = 8'h00;
    tick();
    iv8 = 0;
    flags8("adc_rst", 8'h00, 0, 0, 1, 0, 0);
    tick();

    // WIDTH=16: SAR, CMP, illegal, ROL
    iv16 = 1; op16 = 4'b1010; a16 = 16'h8001; b16 = 16'h0;
    tick();
    flags16("sar16", 16'hC000, 1, 1, 0, 0, 0);
    op16 = 4'b1101; a16 = 16'd5; b16 = 16'd5;
    tick();
    flags16("cmp16", 16'd5, 1, 0, 1, 0, 0);
    op16 = 4'b1101; a16 = 16'd3; b16 = 16'd5;
    tick();
    flags16("cmp16lt", 16'd3, 0, 1, 0, 0, 0);
    op16 = 4'b1111; a16 = 16'h1234; b16 = 16'h5678;
    tick();
    flags16("ill16", 16'h0000, 0, 0, 1, 0, 1);
    op16 = 4'b1011; a16 = 16'h8001;
    tick();
    iv16 = 0;
    flags16("rol16", 16'h0003, 1, 0, 0, 0, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
